rf_wb_ctrl: RTL and testbench
=============================

// Module: rf_wb_ctrl
// PURPOSE
//  Write-side controller for the integer register file. Accepts results from the ALU and LSU
//  over valid/ready channels and arbitrates between them: LSU has priority, and an ALU
//  starvation counter overrides that priority. Drives the register file write port through
//  registered outputs. Keeps a per-register busy scoreboard that decode uses to stall RAW hazards.
// PARAMETERS
//  NBW_ADDR   5   register address width (2**NBW_ADDR registers, x0 hard-wired zero)
//  NBW_DATA   32  register data width
//  MAX_WAIT   4   consecutive ALU-losing cycles before ALU is forced to win (>=1)
// PORTS
//  clk           in   1              clock, all state on rising edge
//  rst_async_n   in   1              asynchronous active-low reset
//  i_alu_vld     in   1              ALU result valid
//  i_alu_rd      in   NBW_ADDR       ALU destination register
//  i_alu_dt      in   NBW_DATA       ALU result data
//  o_alu_rdy     out  1              ALU result accepted this cycle (combinational)
//  i_lsu_vld     in   1              load result valid
//  i_lsu_rd      in   NBW_ADDR       load destination register
//  i_lsu_dt      in   NBW_DATA       load data
//  o_lsu_rdy     out  1              load result accepted this cycle (combinational)
//  i_iss_vld     in   1              decode issues an instruction that writes i_iss_rd
//  i_iss_rd      in   NBW_ADDR       destination of issuing instruction
//  o_iss_rdy     out  1              issue allowed: !busy[i_iss_rd] (always 1 for rd=0)
//  o_busy        out  2**NBW_ADDR    scoreboard, bit r = write to xr pending
//  o_wr_en       out  1              register file write enable
//  o_wr_addr     out  NBW_ADDR       register file write address
//  o_wr_dt       out  NBW_DATA       register file write data
// BEHAVIOUR
//  Reset (async, any time, mid-transfer included): o_wr_en=0, o_wr_addr=0, o_wr_dt=0,
//   o_busy=0, starvation counter=0. Pending inputs are not captured; sources re-present.
//  Arbitration (combinational, single transfer per cycle):
//   force    = (wait_cnt == MAX_WAIT)
//   o_lsu_rdy = !(force && i_alu_vld);  o_alu_rdy = !i_lsu_vld || force
//   A handshake is vld&&rdy. Ready does not depend on the source's own valid. At most one
//   handshake per cycle.
//  Starvation counter wait_cnt (saturates at MAX_WAIT):
//   0 when !i_alu_vld or ALU handshake; +1 when i_alu_vld && !o_alu_rdy.
//  Write port: registered, latency 1. On the cycle after a handshake, o_wr_en=1 with that
//   channel's rd/dt. o_wr_en=0 for rd==0 (transfer still accepted, data dropped).
//   No handshake -> o_wr_en=0 next cycle. o_wr_addr/o_wr_dt hold their last values.
//  Scoreboard, per bit r != 0, evaluated at each rising edge:
//   set   = i_iss_vld && o_iss_rdy && i_iss_rd==r
//   clear = o_wr_en && o_wr_addr==r
//   busy[r] <= set ? 1 : clear ? 0 : busy[r]   (set wins over simultaneous clear)
//   busy[0] is constant 0. Clearing on the edge that writes the register file ensures decode
//   sees the new data as soon as busy drops.
//  Issue with i_iss_vld && !o_iss_rdy: no state change; decode must hold.
//  Results for a register not marked busy are still written (no check, no error).
// TESTING
//  1 Reset mid-transfer: assert rst with o_wr_en=1 -> all outputs 0 immediately,
//    o_busy=0 after release.
//  2 Single ALU result rd=5, dt=0xDEADBEEF -> o_alu_rdy=1; next cycle o_wr_en=1,
//    addr=5, dt=0xDEADBEEF; busy[5] 1->0 after that edge.
//  3 ALU and LSU both valid for 6 cycles, MAX_WAIT=4 -> cycles 0-3 LSU, cycle 4 ALU,
//    cycle 5 LSU; counter returns to 0.
//  4 Write to x0: ALU rd=0, dt=0x1 -> handshake occurs, o_wr_en stays 0, busy[0]=0.
//  5 Issue rd=7 on the cycle busy[7] clears -> busy[7] stays 1 (set wins). Issue rd=7 again
//    while busy -> o_iss_rdy=0, no change.
//  6 Back-to-back LSU results x1, x2, x3, one per cycle -> o_wr_en high 3 consecutive cycles
//    with addrs 1, 2, 3.

Source files
------------

// File: rtl/rf_wb_ctrl_if.sv
// Write-back bundle between the ALU/LSU result channels, decode issue and the register file write port.
// The slave modport is the controller's view of the bundle; master is the producer/consumer side.
interface rf_wb_ctrl_if #(
  parameter int NBW_ADDR = 5,
  parameter int NBW_DATA = 32
);
  logic                   i_alu_vld;
  logic [NBW_ADDR-1:0]    i_alu_rd;
  logic [NBW_DATA-1:0]    i_alu_dt;
  logic                   o_alu_rdy;
  logic                   i_lsu_vld;
  logic [NBW_ADDR-1:0]    i_lsu_rd;
  logic [NBW_DATA-1:0]    i_lsu_dt;
  logic                   o_lsu_rdy;
  logic                   i_iss_vld;
  logic [NBW_ADDR-1:0]    i_iss_rd;
  logic                   o_iss_rdy;
  logic [2**NBW_ADDR-1:0] o_busy;
  logic                   o_wr_en;
  logic [NBW_ADDR-1:0]    o_wr_addr;
  logic [NBW_DATA-1:0]    o_wr_dt;

  modport slave (
    input  i_alu_vld, i_alu_rd, i_alu_dt,
    input  i_lsu_vld, i_lsu_rd, i_lsu_dt,
    input  i_iss_vld, i_iss_rd,
    output o_alu_rdy, o_lsu_rdy, o_iss_rdy,
    output o_busy, o_wr_en, o_wr_addr, o_wr_dt
  );

  modport master (
    output i_alu_vld, i_alu_rd, i_alu_dt,
    output i_lsu_vld, i_lsu_rd, i_lsu_dt,
    output i_iss_vld, i_iss_rd,
    input  o_alu_rdy, o_lsu_rdy, o_iss_rdy,
    input  o_busy, o_wr_en, o_wr_addr, o_wr_dt
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// Register-file write-side controller: LSU-priority arbitration with ALU starvation override,
// registered write port and a per-register busy scoreboard for RAW stalls in decode.
module rf_wb_ctrl #(
  parameter int NBW_ADDR = 5,
  parameter int NBW_DATA = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst_async_n,
  rf_wb_ctrl_if.slave  bus
);

  localparam int NREG    = 2**NBW_ADDR;
  localparam int NBW_CNT = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [NBW_CNT-1:0] CNT_MAX = NBW_CNT'(MAX_WAIT);

  logic [NBW_CNT-1:0]  wait_cnt_q, wait_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [NBW_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [NBW_DATA-1:0] wr_dt_q, wr_dt_d;
  logic [NREG-1:0]     busy_q, busy_d;

  logic force_alu;
  logic alu_rdy, lsu_rdy, iss_rdy;
  logic alu_hs, lsu_hs;

  // Readies never look at the requester's own valid, so at most one handshake can fire.
  always_comb begin
    force_alu = (wait_cnt_q == CNT_MAX);
    lsu_rdy   = !(force_alu && bus.i_alu_vld);
    alu_rdy   = !bus.i_lsu_vld || force_alu;
    alu_hs    = bus.i_alu_vld && alu_rdy;
    lsu_hs    = bus.i_lsu_vld && lsu_rdy;
    iss_rdy   = (bus.i_iss_rd == '0) || !busy_q[bus.i_iss_rd];
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.i_alu_vld || alu_hs) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + NBW_CNT'(1);
    end
  end

  // Address/data hold their last transfer; only the enable pulses.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dt_d   = wr_dt_q;
    if (lsu_hs) begin
      wr_en_d   = (bus.i_lsu_rd != '0);
      wr_addr_d = bus.i_lsu_rd;
      wr_dt_d   = bus.i_lsu_dt;
    end else if (alu_hs) begin
      wr_en_d   = (bus.i_alu_rd != '0);
      wr_addr_d = bus.i_alu_rd;
      wr_dt_d   = bus.i_alu_dt;
    end
  end

  // Set beats a same-edge clear so a fresh issue is never lost behind an older write.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (bus.i_iss_vld && iss_rdy && (bus.i_iss_rd == NBW_ADDR'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_en_q && (wr_addr_q == NBW_ADDR'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wait_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_dt_q    <= '0;
      busy_q     <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_dt_q    <= wr_dt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_alu_rdy = alu_rdy;
  assign bus.o_lsu_rdy = lsu_rdy;
  assign bus.o_iss_rdy = iss_rdy;
  assign bus.o_busy    = busy_q;
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_dt   = wr_dt_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Randomized and directed bench for rf_wb_ctrl against a behavioural write-back model.
module tb_rf_wb_ctrl;
  localparam int NBW_ADDR = 5;
  localparam int NBW_DATA = 32;
  localparam int MAX_WAIT = 4;
  localparam int NREG     = 2**NBW_ADDR;

  logic clk = 1'b0;
  logic rst_async_n;
  always #5 clk = ~clk;

  rf_wb_ctrl_if #(.NBW_ADDR(NBW_ADDR), .NBW_DATA(NBW_DATA)) bus ();

  rf_wb_ctrl #(.NBW_ADDR(NBW_ADDR), .NBW_DATA(NBW_DATA), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: which registers have writes outstanding, how long ALU has been losing,
  // and what the write port shows after the last edge.
  bit                  m_busy [NREG];
  int                  m_wait;
  bit                  m_wen;
  logic [NBW_ADDR-1:0] m_waddr;
  logic [NBW_DATA-1:0] m_wdt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREG-1:0] busy_vec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    m_wait  = 0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdt   = '0;
  endtask

  task automatic drive_idle();
    bus.i_alu_vld = 1'b0; bus.i_alu_rd = '0; bus.i_alu_dt = '0;
    bus.i_lsu_vld = 1'b0; bus.i_lsu_rd = '0; bus.i_lsu_dt = '0;
    bus.i_iss_vld = 1'b0; bus.i_iss_rd = '0;
  endtask

  task automatic chk_port(input string tag);
    chk({tag, "_wr_en"},   bus.o_wr_en,   m_wen);
    chk({tag, "_wr_addr"}, bus.o_wr_addr, m_waddr);
    chk({tag, "_wr_dt"},   bus.o_wr_dt,   m_wdt);
    chk({tag, "_busy"},    bus.o_busy,    busy_vec());
  endtask

  // One cycle: called just after a falling edge, returns on the next falling edge.
  task automatic step(input string tag,
                      input logic av, input logic [NBW_ADDR-1:0] ar, input logic [NBW_DATA-1:0] ad,
                      input logic lv, input logic [NBW_ADDR-1:0] lr, input logic [NBW_DATA-1:0] ld,
                      input logic iv, input logic [NBW_ADDR-1:0] ir);
    bit starved, iss_ok, alu_wins, lsu_wins;
    bus.i_alu_vld = av; bus.i_alu_rd = ar; bus.i_alu_dt = ad;
    bus.i_lsu_vld = lv; bus.i_lsu_rd = lr; bus.i_lsu_dt = ld;
    bus.i_iss_vld = iv; bus.i_iss_rd = ir;
    #1;
    starved  = (m_wait == MAX_WAIT);
    lsu_wins = lv && !(av && starved);
    alu_wins = av && !lsu_wins;
    iss_ok   = (ir == 0) || !m_busy[ir];
    chk({tag, "_alu_rdy"}, bus.o_alu_rdy, !lv || starved);
    chk({tag, "_lsu_rdy"}, bus.o_lsu_rdy, !(starved && av));
    chk({tag, "_iss_rdy"}, bus.o_iss_rdy, iss_ok);

    for (int r = 1; r < NREG; r++) begin
      if (iv && iss_ok && ir == r)          m_busy[r] = 1'b1;
      else if (m_wen && m_waddr == r)       m_busy[r] = 1'b0;
    end
    if (alu_wins || !av) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
    m_wen = 1'b0;
    if (lsu_wins) begin
      m_wen = (lr != 0); m_waddr = lr; m_wdt = ld;
    end else if (alu_wins) begin
      m_wen = (ar != 0); m_waddr = ar; m_wdt = ad;
    end

    @(negedge clk);
    chk_port(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    drive_idle();
    model_reset();
    rst_async_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_port("reset");
    rst_async_n = 1'b1;

    // Single ALU result to x5 after decode marked it busy.
    step("t2_iss", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
    step("t2_alu", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
    chk("t2_wen", bus.o_wr_en, 1'b1);
    chk("t2_addr", bus.o_wr_addr, 5'd5);
    chk("t2_dt", bus.o_wr_dt, 32'hDEADBEEF);
    chk("t2_busy5_before", bus.o_busy[5], 1'b1);
    idle("t2_idle");
    chk("t2_busy5_after", bus.o_busy[5], 1'b0);

    // Contention: LSU wins four times, then the starved ALU is forced through once.
    for (int i = 0; i < 6; i++) begin
      step("t3", 1'b1, 5'd9, 32'hA100_0000 + i, 1'b1, 5'd10, 32'hB100_0000 + i, 1'b0, '0);
      chk("t3_src", bus.o_wr_dt, (i == 4) ? 32'hA100_0000 + i : 32'hB100_0000 + i);
    end
    idle("t3_idle");

    // Write to x0 is accepted but never reaches the register file.
    step("t4", 1'b1, 5'd0, 32'h1, 1'b0, '0, '0, 1'b0, '0);
    chk("t4_wen", bus.o_wr_en, 1'b0);
    chk("t4_busy0", bus.o_busy[0], 1'b0);

    // Issue to x7 on the edge where a write to x7 clears it: the issue must stick.
    step("t5_wr", 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0, '0);
    step("t5_iss", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
    chk("t5_busy7_set", bus.o_busy[7], 1'b1);
    step("t5_again", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
    chk("t5_busy7_hold", bus.o_busy[7], 1'b1);

    // Back-to-back loads to x1..x3.
    for (int i = 1; i <= 3; i++) begin
      step("t6", 1'b0, '0, '0, 1'b1, NBW_ADDR'(i), 32'hC0 + i, 1'b0, '0);
      chk("t6_wen", bus.o_wr_en, 1'b1);
      chk("t6_addr", bus.o_wr_addr, NBW_ADDR'(i));
    end

    // Asynchronous reset while the write port is active.
    chk("t1_pre_wen", bus.o_wr_en, 1'b1);
    #2 rst_async_n = 1'b0;
    #1;
    model_reset();
    chk_port("t1_rst");
    @(negedge clk);
    rst_async_n = 1'b1;
    chk("t1_busy_rel", bus.o_busy, '0);

    // Random traffic over a small register window to force collisions.
    for (int n = 0; n < 600; n++) begin
      step("rnd",
           ($urandom_range(0, 99) < 60), NBW_ADDR'($urandom_range(0, 7)), NBW_DATA'($urandom),
           ($urandom_range(0, 99) < 55), NBW_ADDR'($urandom_range(0, 7)), NBW_DATA'($urandom),
           ($urandom_range(0, 99) < 50), NBW_ADDR'($urandom_range(0, 7)));
    end

    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
